seg7_scan_capture: RTL and testbench

Receive-side counterpart of the hex-to-seven-segment encoder. Watches a multiplexed, active-low seven-segment display bus (segment lines plus per-digit anode strobes) and qualifies each digit dwell for stability. It then decodes the segment pattern back to a 4-bit hex value and holds one nibble per digit position. Used as a loopback monitor on the display path and as a scoreboard source for on-board self-test.

---
 rtl/seg7_scan_capture.sv | 166 ++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture
// Loopback monitor for a multiplexed, active-low seven-segment display bus.
// Each digit dwell is qualified for stability, decoded back to a hex nibble,
// and stored per digit position.
//
// Optional feature macro: SEG7_BLANK_EN
//   defined   : seg_n = 7'h7F with one active anode is a legal blank
//               (valid/err cleared, nibble kept)
//   undefined : 7'h7F is an unrecognised pattern (err set)
//
// Parameters
//   NDIG   : number of digit positions (1..8)
//   STABLE : identical registered samples required before capture (>= 2)
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   seg_n     in   [6:0] segment bus {g,f,e,d,c,b,a}, active-low
//   an_n      in   [NDIG-1:0] anode strobes, active-low
//   digits    out  [4*NDIG-1:0] captured nibbles, digit i at [4i+3:4i]
//   valid     out  [NDIG-1:0] digit holds a decoded value
//   err       out  [NDIG-1:0] last capture on digit was unrecognised
//   update    out  one-cycle pulse per capture
//   digit_idx out  [2:0] digit captured, meaningful while update = 1
//
// state | meaning
// IDLE  | anode field not one-hot-low; no capture possible
// TRACK | single anode active; waiting for cnt to reach STABLE
// DONE  | captured this dwell; waiting for the sample to change
module seg7_scan_capture #(
  parameter int NDIG   = 4,
  parameter int STABLE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        seg_n,
  input  logic [NDIG-1:0]   an_n,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   valid,
  output logic [NDIG-1:0]   err,
  output logic              update,
  output logic [2:0]        digit_idx
);

  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);

  typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;

  state_t            state;
  logic [6:0]        s_seg;
  logic [NDIG-1:0]   s_an;
  logic [CW-1:0]     cnt;

  logic              one_low;
  logic [2:0]        sel;
  logic [3:0]        n_low;
  logic              dec_ok;
  logic [3:0]        dec_nib;
  logic              is_blank;

  // Count low anodes in the registered sample and remember the low one.
  always_comb begin
    n_low = 4'd0;
    sel   = 3'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (!s_an[i]) begin
        n_low = n_low + 4'd1;
        sel   = 3'(i);
      end
    end
    one_low = (n_low == 4'd1);
  end

  always_comb begin
    dec_ok  = 1'b1;
    dec_nib = 4'h0;
    case (s_seg)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

`ifdef SEG7_BLANK_EN
  assign is_blank = (s_seg == 7'h7F);
`else
  assign is_blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_seg     <= '1;
      s_an      <= '1;
      cnt       <= '0;
      state     <= IDLE;
      digits    <= '0;
      valid     <= '0;
      err       <= '0;
      update    <= 1'b0;
      digit_idx <= 3'd0;
    end else begin
      s_seg  <= seg_n;
      s_an   <= an_n;
      update <= 1'b0;

      if ({an_n, seg_n} != {s_an, s_seg})
        cnt <= CW'(1);
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;

      case (state)
        IDLE: begin
          if (one_low)
            state <= TRACK;
        end
        TRACK: begin
          if (!one_low) begin
            state <= IDLE;
          end else if (cnt == CNT_MAX) begin
            state     <= DONE;
            update    <= 1'b1;
            digit_idx <= sel;
            // Constant-index loop keeps every bit select in range for any NDIG.
            for (int i = 0; i < NDIG; i++) begin
              if (sel == 3'(i)) begin
                if (is_blank) begin
                  valid[i] <= 1'b0;
                  err[i]   <= 1'b0;
                end else if (dec_ok) begin
                  digits[4*i +: 4] <= dec_nib;
                  valid[i]         <= 1'b1;
                  err[i]           <= 1'b0;
                end else begin
                  valid[i] <= 1'b0;
                  err[i]   <= 1'b1;
                end
              end
            end
          end
        end
        DONE: begin
          // cnt drops below STABLE only when the sample has just changed.
          if (cnt != CNT_MAX)
            state <= one_low ? TRACK : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
module tb_seg7_scan_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] digits;
  logic [3:0]  valid;
  logic [3:0]  err;
  logic        update;
  logic [2:0]  digit_idx;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int dbl_cnt = 0;
  logic prev_upd = 1'b0;
  int base;

  logic [6:0] scan_pat [4];

  seg7_scan_capture #(.NDIG(4), .STABLE(8)) dut (
    .clk(clk), .reset(reset), .seg_n(seg_n), .an_n(an_n),
    .digits(digits), .valid(valid), .err(err),
    .update(update), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (update) upd_cnt++;
    if (update && prev_upd) dbl_cnt++;
    prev_upd = update;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    scan_pat[0] = 7'h79;
    scan_pat[1] = 7'h08;
    scan_pat[2] = 7'h46;
    scan_pat[3] = 7'h0E;

    // Reset with idle bus
    reset = 1'b1;
    an_n  = 4'b1111;
    seg_n = 7'h7F;
    #1;
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_update", 32'(update), 32'h0);
    check("rst_idx", 32'(digit_idx), 32'h0);
    step(2);
    reset = 1'b0;
    base = upd_cnt;
    step(20);
    check("idle_no_update", 32'(upd_cnt - base), 32'd0);

    // Single digit, latency
    an_n  = 4'b1110;
    seg_n = 7'h24;
    base  = upd_cnt;
    step(8);
    check("single_early", 32'(update), 32'd0);
    step(1);
    check("single_update", 32'(update), 32'd1);
    check("single_idx", 32'(digit_idx), 32'd0);
    check("single_digits", 32'(digits), 32'h0002);
    check("single_valid", 32'(valid), 32'h1);
    step(11);
    check("single_count", 32'(upd_cnt - base), 32'd1);

    // Glitch rejection
    an_n  = 4'b1101;
    seg_n = 7'h19;
    base  = upd_cnt;
    step(5);
    seg_n = 7'h12;
    step(20);
    check("glitch_count", 32'(upd_cnt - base), 32'd1);
    check("glitch_digits", 32'(digits), 32'h0052);
    check("glitch_valid", 32'(valid), 32'h3);

    // Unrecognised pattern after preload of 0xC
    an_n  = 4'b1011;
    seg_n = 7'h46;
    step(12);
    check("preload_digits", 32'(digits), 32'h0C52);
    seg_n = 7'h7E;
    base  = upd_cnt;
    step(12);
    check("unrec_count", 32'(upd_cnt - base), 32'd1);
    check("unrec_err", 32'(err), 32'h4);
    check("unrec_valid", 32'(valid), 32'h3);
    check("unrec_digits", 32'(digits), 32'h0C52);

    // Reset in the middle of a dwell
    an_n  = 4'b0111;
    seg_n = 7'h40;
    step(4);
    reset = 1'b1;
    #1;
    check("midrst_digits", 32'(digits), 32'h0);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_err", 32'(err), 32'h0);
    step(1);
    reset = 1'b0;
    base  = upd_cnt;
    step(8);
    check("midrst_early", 32'(update), 32'd0);
    step(1);
    check("midrst_update", 32'(update), 32'd1);
    check("midrst_idx", 32'(digit_idx), 32'd3);
    check("midrst_valid2", 32'(valid), 32'h8);
    check("midrst_count", 32'(upd_cnt - base), 32'd1);

    // Illegal strobes
    an_n  = 4'b1100;
    seg_n = 7'h40;
    base  = upd_cnt;
    step(30);
    check("illegal_count", 32'(upd_cnt - base), 32'd0);
    check("illegal_digits", 32'(digits), 32'h0000);
    check("illegal_valid", 32'(valid), 32'h8);

    // Full scan, two passes
    base = upd_cnt;
    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < 4; d++) begin
        an_n  = ~(4'b0001 << d);
        seg_n = scan_pat[d];
        step(12);
      end
    end
    check("scan_digits", 32'(digits), 32'hFCA1);
    check("scan_valid", 32'(valid), 32'hF);
    check("scan_err", 32'(err), 32'h0);
    check("scan_count", 32'(upd_cnt - base), 32'd8);

    // Blank on digit 1 (holding 0xA)
    an_n  = 4'b1101;
    seg_n = 7'h7F;
    step(12);
`ifdef SEG7_BLANK_EN
    check("blank_err", 32'(err), 32'h0);
    check("blank_valid", 32'(valid), 32'hD);
`else
    check("blank_err", 32'(err), 32'h2);
    check("blank_valid", 32'(valid), 32'hD);
`endif
    check("blank_digits", 32'(digits), 32'hFCA1);

    check("no_back_to_back", 32'(dbl_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
